mipi_csi_rx_raw_depacker_gen: RTL and testbench

Parametrised successor RAW depacker for the CSI-2 receive path. It sits between the packet decoder and the line/pixel buffer. It takes LANES payload bytes per beat and emits PIXEL_PER_CLK left-aligned pixels per output beat. It supports RAW8/10/12/14 with a byte-accurate gearbox, so it is independent of lane count and burst patterns, and it adds per-line pixel counting plus residual and unsupported-type error flags.

---
 rtl/mipi_csi_rx_raw_depacker_gen.sv | 191 +++++++++++++++++++
 tb/tb_mipi_csi_rx_raw_depacker_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_rx_raw_depacker_gen.sv
// CSI-2 RAW8/10/12/14 depacker: byte gearbox from LANES-byte payload beats to
// PIXEL_PER_CLK MSB-aligned pixels, with per-line pixel count and error flags.
module mipi_csi_rx_raw_depacker_gen #(
    parameter int LANES         = 4,
    parameter int PIXEL_PER_CLK = 4,
    parameter int PIXEL_WIDTH   = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 data_valid_i,
    input  logic [8*LANES-1:0]                   data_i,
    input  logic [2:0]                           packet_type_i,
    output logic                                 output_valid_o,
    output logic [PIXEL_WIDTH*PIXEL_PER_CLK-1:0] output_o,
    output logic                                 line_done_o,
    output logic [15:0]                          line_pixels_o,
    output logic                                 residual_err_o,
    output logic                                 unsupported_o
);
    localparam logic [2:0] RAW8  = 3'd2;
    localparam logic [2:0] RAW10 = 3'd3;
    localparam logic [2:0] RAW12 = 3'd4;
    localparam logic [2:0] RAW14 = 3'd5;

    localparam int GROUPS = PIXEL_PER_CLK / 4;
    localparam int CAP    = 7 * GROUPS + LANES - 1;
    localparam int BUF_W  = 8 * CAP;
    localparam int OCC_W  = $clog2(CAP + 1);
    localparam int OUT_W  = PIXEL_WIDTH * PIXEL_PER_CLK;
    localparam logic [15:0] PPC16 = 16'(PIXEL_PER_CLK);

    // Unpacks one 4-pixel group (up to 7 bytes, oldest byte in bits [7:0]) into
    // four 14-bit MSB-aligned pixels.
    function automatic logic [55:0] unpack4(input logic [2:0] t, input logic [55:0] g);
        logic [55:0] r;
        logic [23:0] w;
        r = '0;
        w = g[55:32];
        for (int p = 0; p < 4; p++) begin
            case (t)
                RAW10:   r[14*p +: 14] = {g[8*p +: 8], g[32+2*p +: 2], 4'b0};
                RAW12:   r[14*p +: 14] = {g[8*((p/2)*3 + p%2) +: 8],
                                          g[24*(p/2) + 16 + 4*(p%2) +: 4], 2'b0};
                RAW14:   r[14*p +: 14] = {g[8*p +: 8], w[6*p +: 6]};
                default: r[14*p +: 14] = {g[8*p +: 8], 6'b0};
            endcase
        end
        return r;
    endfunction

    logic [8*LANES-1:0] data_reg_q;
    logic               valid_reg_q;
    logic [2:0]         ptype_reg_q;
    logic [2:0]         type_q, type_d;
    logic               line_active_q, line_active_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               line_done_q, line_done_d;
    logic [15:0]        line_pixels_q, line_pixels_d;
    logic               residual_q, residual_d;
    logic               unsupported_q, unsupported_d;

    logic               line_start, line_end, supported, emit;
    logic [2:0]         cur_type;
    logic [OCC_W-1:0]   grp_bytes, beat_bytes, occ_app;
    logic [BUF_W-1:0]   appended;
    logic [55:0]        quad;
    logic [OUT_W-1:0]   pixels;
    logic [15:0]        cnt_base;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        line_start = valid_reg_q && !line_active_q;
        line_end   = !valid_reg_q && line_active_q;
        // The first beat of a line decodes with its own type, not last line's.
        cur_type   = line_start ? ptype_reg_q : type_q;
        supported  = (cur_type >= RAW8) && (cur_type <= RAW14);
        case (cur_type)
            RAW10:   grp_bytes = OCC_W'(5);
            RAW12:   grp_bytes = OCC_W'(6);
            RAW14:   grp_bytes = OCC_W'(7);
            default: grp_bytes = OCC_W'(4);
        endcase
        beat_bytes = grp_bytes * OCC_W'(GROUPS);
        appended   = buf_q | (BUF_W'(data_reg_q) << (8 * occ_q));
        occ_app    = occ_q + OCC_W'(LANES);
        emit       = valid_reg_q && supported && (occ_app >= beat_bytes);
        cnt_base   = line_start ? 16'd0 : cnt_q;

        pixels = '0;
        quad   = '0;
        for (int q = 0; q < GROUPS; q++) begin
            quad = unpack4(cur_type, 56'(appended >> (8 * grp_bytes * q)));
            for (int p = 0; p < 4; p++)
                pixels[PIXEL_WIDTH*(4*q+p) +: PIXEL_WIDTH] =
                    PIXEL_WIDTH'(quad[14*p +: 14]) << (PIXEL_WIDTH - 14);
        end

        type_d        = type_q;
        line_active_d = line_active_q;
        buf_d         = buf_q;
        occ_d         = occ_q;
        cnt_d         = cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        line_done_d   = 1'b0;
        line_pixels_d = line_pixels_q;
        residual_d    = 1'b0;
        unsupported_d = unsupported_q;

        if (line_start) begin
            type_d        = ptype_reg_q;
            cnt_d         = 16'd0;
            unsupported_d = !supported;
            line_active_d = 1'b1;
        end

        // Unsupported payload is simply never appended, so it is discarded.
        if (valid_reg_q && supported) begin
            if (emit) begin
                out_data_d  = pixels;
                out_valid_d = 1'b1;
                buf_d       = appended >> (8 * beat_bytes);
                occ_d       = occ_app - beat_bytes;
                cnt_d       = (cnt_base > 16'hFFFF - PPC16) ? 16'hFFFF : cnt_base + PPC16;
            end else begin
                buf_d = appended;
                occ_d = occ_app;
            end
        end

        if (line_end) begin
            line_done_d   = 1'b1;
            line_pixels_d = cnt_q;
            residual_d    = (occ_q != '0);
            buf_d         = '0;
            occ_d         = '0;
            line_active_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_reg_q    <= '0;
            valid_reg_q   <= 1'b0;
            ptype_reg_q   <= '0;
            type_q        <= RAW8;
            line_active_q <= 1'b0;
            // NOTE: the byte buffer is a flop vector, not a RAM, so it is
            // cleared here and an aborted line cannot leak bytes into the next.
            buf_q         <= '0;
            occ_q         <= '0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            line_done_q   <= 1'b0;
            line_pixels_q <= '0;
            residual_q    <= 1'b0;
            unsupported_q <= 1'b0;
        end else begin
            data_reg_q    <= data_i;
            valid_reg_q   <= data_valid_i;
            ptype_reg_q   <= packet_type_i;
            type_q        <= type_d;
            line_active_q <= line_active_d;
            buf_q         <= buf_d;
            occ_q         <= occ_d;
            cnt_q         <= cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            line_done_q   <= line_done_d;
            line_pixels_q <= line_pixels_d;
            residual_q    <= residual_d;
            unsupported_q <= unsupported_d;
        end
    end

    assign output_valid_o = out_valid_q;
    assign output_o       = out_data_q;
    assign line_done_o    = line_done_q;
    assign line_pixels_o  = line_pixels_q;
    assign residual_err_o = residual_q;
    assign unsupported_o  = unsupported_q;

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_gen.sv
// Directed bench for the RAW depacker: three instances cover LANES/PIXEL_PER_CLK
// combinations 4/4, 2/4 and 8/8 with hand-computed expected pixels.
module tb_mipi_csi_rx_raw_depacker_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: LANES=4, PPC=4
    logic        a_dv = 1'b0;
    logic [31:0] a_data = '0;
    logic [2:0]  a_type = '0;
    logic        a_valid, a_done, a_res, a_uns;
    logic [63:0] a_out;
    logic [15:0] a_pix;

    // Instance B: LANES=2, PPC=4
    logic        b_dv = 1'b0;
    logic [15:0] b_data = '0;
    logic [2:0]  b_type = '0;
    logic        b_valid, b_done, b_res, b_uns;
    logic [63:0] b_out;
    logic [15:0] b_pix;

    // Instance C: LANES=8, PPC=8
    logic         c_dv = 1'b0;
    logic [63:0]  c_data = '0;
    logic [2:0]   c_type = '0;
    logic         c_valid, c_done, c_res, c_uns;
    logic [127:0] c_out;
    logic [15:0]  c_pix;

    mipi_csi_rx_raw_depacker_gen #(.LANES(4), .PIXEL_PER_CLK(4), .PIXEL_WIDTH(16)) dut_a (
        .clk_i(clk), .reset_i(rst), .data_valid_i(a_dv), .data_i(a_data),
        .packet_type_i(a_type), .output_valid_o(a_valid), .output_o(a_out),
        .line_done_o(a_done), .line_pixels_o(a_pix), .residual_err_o(a_res),
        .unsupported_o(a_uns));

    mipi_csi_rx_raw_depacker_gen #(.LANES(2), .PIXEL_PER_CLK(4), .PIXEL_WIDTH(16)) dut_b (
        .clk_i(clk), .reset_i(rst), .data_valid_i(b_dv), .data_i(b_data),
        .packet_type_i(b_type), .output_valid_o(b_valid), .output_o(b_out),
        .line_done_o(b_done), .line_pixels_o(b_pix), .residual_err_o(b_res),
        .unsupported_o(b_uns));

    mipi_csi_rx_raw_depacker_gen #(.LANES(8), .PIXEL_PER_CLK(8), .PIXEL_WIDTH(16)) dut_c (
        .clk_i(clk), .reset_i(rst), .data_valid_i(c_dv), .data_i(c_data),
        .packet_type_i(c_type), .output_valid_o(c_valid), .output_o(c_out),
        .line_done_o(c_done), .line_pixels_o(c_pix), .residual_err_o(c_res),
        .unsupported_o(c_uns));

    // Event logs, sampled on the falling edge.
    logic [63:0]  a_outs[$];
    int           a_out_cyc[$];
    logic [15:0]  a_done_pix[$];
    logic         a_done_res[$];
    int           a_done_cyc[$];
    logic [63:0]  b_outs[$];
    int           b_out_cyc[$];
    logic [15:0]  b_done_pix[$];
    logic         b_done_res[$];
    int           b_done_cyc[$];
    logic [127:0] c_outs[$];
    int           c_out_cyc[$];
    logic [15:0]  c_done_pix[$];
    logic         c_done_res[$];
    int           c_done_cyc[$];

    always @(negedge clk) begin
        if (a_valid) begin a_outs.push_back(a_out); a_out_cyc.push_back(cyc); end
        if (a_done) begin a_done_pix.push_back(a_pix); a_done_res.push_back(a_res); a_done_cyc.push_back(cyc); end
        if (b_valid) begin b_outs.push_back(b_out); b_out_cyc.push_back(cyc); end
        if (b_done) begin b_done_pix.push_back(b_pix); b_done_res.push_back(b_res); b_done_cyc.push_back(cyc); end
        if (c_valid) begin c_outs.push_back(c_out); c_out_cyc.push_back(cyc); end
        if (c_done) begin c_done_pix.push_back(c_pix); c_done_res.push_back(c_res); c_done_cyc.push_back(cyc); end
    end

    localparam logic [15:0] B_BEATS [7] = '{16'h2211, 16'h4433, 16'h0FC0, 16'h55FC,
                                             16'h7766, 16'hFF88, 16'h0000};

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_a();
        a_outs.delete(); a_out_cyc.delete();
        a_done_pix.delete(); a_done_res.delete(); a_done_cyc.delete();
    endtask

    task automatic a_beat(input logic [2:0] t, input logic [31:0] d);
        @(negedge clk);
        a_dv = 1'b1; a_type = t; a_data = d;
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_dv = 1'b0; a_data = '0;
        end
    endtask

    task automatic check_line_a(input string tag, input int n_out, input logic [15:0] pix);
        check({tag, "_nout"}, a_outs.size(), n_out);
        check({tag, "_ndone"}, a_done_cyc.size(), 1);
        if (a_done_cyc.size() > 0) check({tag, "_pix"}, a_done_pix[0], pix);
        if (a_done_cyc.size() > 0 && a_outs.size() > 0)
            check({tag, "_gap"}, a_done_cyc[0] - a_out_cyc[a_out_cyc.size()-1], 1);
    endtask

    function automatic logic [63:0] c_beat(input int i);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(8*i + j);
        return r;
    endfunction

    function automatic logic [127:0] c_exp(input int i);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[16*j +: 16] = {8'(8*i + j), 8'h00};
        return r;
    endfunction

    int b_c0;
    int c_last;

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_valid", a_valid, 0);
        check("rst_out", a_out, 0);
        check("rst_done", a_done, 0);
        check("rst_pix", a_pix, 0);
        check("rst_res", a_res, 0);
        check("rst_uns", a_uns, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        a_idle(2);

        // RAW10, bytes 00..07: one group after 5 bytes, 3 bytes left over
        clear_a();
        a_beat(3'd3, 32'h03020100);
        a_beat(3'd3, 32'h07060504);
        a_idle(6);
        check_line_a("raw10", 1, 16'd4);
        if (a_outs.size() > 0) check("raw10_px", a_outs[0], 64'h0300_0200_0140_0000);
        if (a_done_res.size() > 0) check("raw10_res", a_done_res[0], 1);

        // RAW12, 12 bytes; the type input changes mid-line and must be ignored
        clear_a();
        a_beat(3'd4, 32'h1221CDAB);
        a_beat(3'd5, 32'hBC9A5634);
        a_beat(3'd2, 32'hE302017F);
        a_idle(6);
        check_line_a("raw12", 2, 16'd8);
        if (a_outs.size() > 0) check("raw12_px0", a_outs[0], 64'h3450_1260_CD20_AB10);
        if (a_outs.size() > 1) check("raw12_px1", a_outs[1], 64'h02E0_0130_BC70_9AF0);
        if (a_done_res.size() > 0) check("raw12_res", a_done_res[0], 0);

        // Unsupported type 6, 10 beats
        clear_a();
        for (int i = 0; i < 10; i++) begin
            a_beat(3'd6, 32'hA5A5_0000 + 32'(i));
            if (i == 3) check("uns_level", a_uns, 1);
        end
        a_idle(6);
        check("uns_hold", a_uns, 1);
        check_line_a("uns", 0, 16'd0);

        // Next RAW10 line clears the flag and decodes normally
        clear_a();
        a_beat(3'd3, 32'h03020100);
        a_beat(3'd3, 32'h07060504);
        a_idle(6);
        check("uns_clear", a_uns, 0);
        check_line_a("raw10b", 1, 16'd4);
        if (a_outs.size() > 0) check("raw10b_px", a_outs[0], 64'h0300_0200_0140_0000);

        // Reset in the middle of a RAW10 line, between clock edges
        clear_a();
        a_beat(3'd3, 32'h23222120);
        a_beat(3'd3, 32'h27262524);
        a_beat(3'd3, 32'h2B2A2928);
        a_beat(3'd3, 32'h2F2E2D2C);
        #2 rst = 1'b1;
        #1;
        check("midrst_out", a_out, 0);
        check("midrst_valid", a_valid, 0);
        check("midrst_pix", a_pix, 0);
        a_dv = 1'b0; a_data = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        clear_a();
        a_idle(6);
        check("midrst_nodone", a_done_cyc.size(), 0);
        a_beat(3'd3, 32'h13121110);
        a_beat(3'd3, 32'h17161514);
        a_idle(6);
        check_line_a("postrst", 1, 16'd4);
        if (a_outs.size() > 0) check("postrst_px", a_outs[0], 64'h1300_1240_1140_1000);
        if (a_done_res.size() > 0) check("postrst_res", a_done_res[0], 1);

        // RAW14 on LANES=2: groups complete on beats 4 and 7
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) b_c0 = cyc;
            b_dv = 1'b1; b_type = 3'd5; b_data = B_BEATS[i];
        end
        @(negedge clk);
        b_dv = 1'b0; b_data = '0;
        repeat (6) @(negedge clk);
        check("raw14_nout", b_outs.size(), 2);
        check("raw14_ndone", b_done_cyc.size(), 1);
        if (b_outs.size() > 0) check("raw14_px0", b_outs[0], 64'h44FC_3300_22FC_1100);
        if (b_outs.size() > 1) check("raw14_px1", b_outs[1], 64'h8800_7700_660C_55FC);
        if (b_outs.size() > 0) check("raw14_lat0", b_out_cyc[0] - b_c0, 5);
        if (b_outs.size() > 1) check("raw14_lat1", b_out_cyc[1] - b_c0, 8);
        if (b_done_cyc.size() > 0) begin
            check("raw14_done_lat", b_done_cyc[0] - b_c0, 9);
            check("raw14_pix", b_done_pix[0], 8);
            check("raw14_res", b_done_res[0], 0);
        end

        // RAW8 on LANES=8, PPC=8: 640 back-to-back beats
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            c_dv = 1'b1; c_type = 3'd2; c_data = c_beat(i);
        end
        @(negedge clk);
        c_dv = 1'b0; c_data = '0;
        repeat (6) @(negedge clk);
        check("raw8_nout", c_outs.size(), 640);
        for (int i = 0; i < c_outs.size(); i++) check("raw8_px", c_outs[i], c_exp(i));
        check("raw8_ndone", c_done_cyc.size(), 1);
        if (c_outs.size() > 0) begin
            c_last = c_out_cyc[c_out_cyc.size()-1];
            check("raw8_contig", c_last - c_out_cyc[0], 639);
            if (c_done_cyc.size() > 0) check("raw8_gap", c_done_cyc[0] - c_last, 1);
        end
        if (c_done_cyc.size() > 0) begin
            check("raw8_pix", c_done_pix[0], 16'd5120);
            check("raw8_res", c_done_res[0], 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
